mux_4to1_sel_case: RTL and testbench



---
 rtl/mux_4to1_sel_pkg.sv | 11 +
 rtl/mux_4to1_comb.sv | 28 ++
 rtl/mux_4to1_sel_case.sv | 84 ++++++++
 tb/tb_mux_4to1_sel_case.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mux_4to1_sel_pkg.sv
// Shared select encoding for the 4:1 select-case multiplexer.
package mux_4to1_sel_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

endpackage : mux_4to1_sel_pkg

// File: rtl/mux_4to1_comb.sv
// Pure combinational 4:1 decode. An unknown select falls to the default
// arm and yields zero, so X/Z on sel never propagates as a data word.
module mux_4to1_comb
  import mux_4to1_sel_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] out
);

  // Full case decode of the select onto one of the four data words.
  always_comb begin
    // NOTE: out gets a value on every path (default arm), so no latch is inferred.
    case (sel)
      SEL_A:   out = a;
      SEL_B:   out = b;
      SEL_C:   out = c;
      SEL_D:   out = d;
      default: out = '0;
    endcase
  end

endmodule : mux_4to1_comb

// File: rtl/mux_4to1_sel_case.sv
// 4:1 multiplexer with a zero-latency output and a registered copy.
// The registered copy carries a valid flag and a one-cycle select-change
// pulse. Defining MUX_PARITY_EN adds a registered even-parity bit out_par
// covering out_q.
module mux_4to1_sel_case
  import mux_4to1_sel_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_vld,
  output logic             sel_chg
`ifdef MUX_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [WIDTH-1:0] out_d;
  logic             vld_q, vld_d;
  sel_t             sel_q, sel_d;
  logic             chg_q, chg_d;
`ifdef MUX_PARITY_EN
  logic             par_q, par_d;
`endif

  mux_4to1_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .out (out)
  );

  // Next-state values; the change pulse is gated by vld_q so the first
  // sample after reset never reports a change against the reset select.
  always_comb begin
    out_d = out;
    vld_d = 1'b1;
    sel_d = sel;
    chg_d = (sel != sel_q) && vld_q;
`ifdef MUX_PARITY_EN
    par_d = ^out;
`endif
  end

  // Output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
      sel_q <= SEL_A;
      chg_q <= 1'b0;
`ifdef MUX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      sel_q <= sel_d;
      chg_q <= chg_d;
`ifdef MUX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  assign out_vld = vld_q;
  assign sel_chg = chg_q;
`ifdef MUX_PARITY_EN
  assign out_par = par_q;
`endif

endmodule : mux_4to1_sel_case

// File: tb/tb_mux_4to1_sel_case.sv
// Self-checking bench for mux_4to1_sel_case (WIDTH=4): directed scenarios
// followed by random stimulus against a behavioural reference model.
module tb_mux_4to1_sel_case;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, c, d;
  logic [1:0] sel;
  logic [3:0] out, out_q;
  logic       out_vld, sel_chg;
`ifdef MUX_PARITY_EN
  logic       out_par;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model of the registered outputs.
  logic [3:0] m_q;
  logic       m_vld;
  logic [1:0] m_sel_q;
  logic       m_chg;
  logic       m_par;

  mux_4to1_sel_case #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .sel     (sel),
    .out     (out),
    .out_q   (out_q),
    .out_vld (out_vld),
    .sel_chg (sel_chg)
`ifdef MUX_PARITY_EN
    ,
    .out_par (out_par)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive on negedge, check combinational output, then
  // advance the model at the rising edge and check the registered outputs.
  task automatic step(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic,
                      input logic [3:0] id, input logic [1:0] isel, input logic irst);
    logic [3:0] words [4];
    logic [3:0] exp_out;
    logic       nchg;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; sel = isel; rst = irst;
    #1;
    words   = '{ia, ib, ic, id};
    exp_out = words[isel];
    check("comb_out", 64'(out), 64'(exp_out));
    @(posedge clk);
    if (irst) begin
      m_q = '0; m_vld = 1'b0; m_sel_q = 2'd0; m_chg = 1'b0; m_par = 1'b0;
    end else begin
      nchg    = (isel != m_sel_q) && m_vld;
      m_q     = exp_out;
      m_vld   = 1'b1;
      m_sel_q = isel;
      m_chg   = nchg;
      m_par   = ^exp_out;
    end
    #1;
    check("out_q", 64'(out_q), 64'(m_q));
    check("out_vld", 64'(out_vld), 64'(m_vld));
    check("sel_chg", 64'(sel_chg), 64'(m_chg));
`ifdef MUX_PARITY_EN
    check("out_par", 64'(out_par), 64'(m_par));
    if (out_vld) check("even_parity", 64'(^{out_q, out_par}), 64'(0));
`endif
  endtask

  initial begin
    logic [3:0] plan [4];
    plan = '{4'h4, 4'h1, 4'h9, 4'h3};
    rst = 1'b1;
    a = 4'h4; b = 4'h1; c = 4'h9; d = 4'h3; sel = 2'd0;
    m_q = '0; m_vld = 1'b0; m_sel_q = 2'd0; m_chg = 1'b0; m_par = 1'b0;

    // Static decode: sel stepped with data fixed, out follows immediately.
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check("static_decode", 64'(out), 64'(plan[i]));
      #4;
    end

    // Reset two cycles with sel=2, then release.
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd2, 1'b1);
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd2, 1'b1);
    check("rst_vld_low", 64'(out_vld), 64'(0));
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd2, 1'b0);
    check("first_q", 64'(out_q), 64'(4'h9));
    check("first_vld", 64'(out_vld), 64'(1));
    check("first_chg", 64'(sel_chg), 64'(0));

    // Hold sel=0 three cycles, then switch to sel=3.
    for (int i = 0; i < 3; i++) step(4'h4, 4'h1, 4'h9, 4'h3, 2'd0, 1'b0);
    check("hold_chg", 64'(sel_chg), 64'(0));
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd3, 1'b0);
    check("switch_q", 64'(out_q), 64'(4'h3));
    check("switch_chg", 64'(sel_chg), 64'(1));
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd3, 1'b0);
    check("switch_chg_drop", 64'(sel_chg), 64'(0));

    // Data change under fixed sel=1.
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd1, 1'b0);
    step(4'h4, 4'hF, 4'h9, 4'h3, 2'd1, 1'b0);
    check("data_q", 64'(out_q), 64'(4'hF));
    check("data_chg", 64'(sel_chg), 64'(0));

    // Reset mid-run: comb path keeps following inputs.
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd3, 1'b0);
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd3, 1'b1);
    check("midrst_q", 64'(out_q), 64'(0));
    check("midrst_vld", 64'(out_vld), 64'(0));
    check("midrst_out", 64'(out), 64'(4'h3));
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd3, 1'b0);
    check("post_rst_chg", 64'(sel_chg), 64'(0));

    // Parity scenario (sel=2, c=7 then c=9).
    step(4'h4, 4'h1, 4'h7, 4'h3, 2'd2, 1'b0);
    check("par_q7", 64'(out_q), 64'(4'h7));
`ifdef MUX_PARITY_EN
    check("par_bit7", 64'(out_par), 64'(1));
`endif
    step(4'h4, 4'h1, 4'h9, 4'h3, 2'd2, 1'b0);
`ifdef MUX_PARITY_EN
    check("par_bit9", 64'(out_par), 64'(0));
`endif

    // Random stimulus with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_4to1_sel_case
